// File: rtl/led_scan_decoder.sv
// LED scan decoder: synchronizes a row-scanned LED board bus and rebuilds
// complete red/green frames. A frame is published only after rows 0..15 have
// been captured in order. Out-of-order rows and scan gaps are flagged.
module led_scan_decoder #(
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        scan_row,
    input  logic [15:0]       scan_red,
    input  logic [15:0]       scan_grn,
    input  logic              scan_latch,
    output logic [15:0][15:0] RedPixels,
    output logic [15:0][15:0] GrnPixels,
    output logic              frame_valid,
    output logic [7:0]        frame_count,
    output logic              sync_err,
    output logic              scan_lost
);

    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT);
    localparam int              LAST   = SYNC_STAGES - 1;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // Synchronizer chains; index LAST is the fully synchronized value.
    logic [SYNC_STAGES-1:0][3:0]  row_sync_r;
    logic [SYNC_STAGES-1:0][15:0] red_sync_r;
    logic [SYNC_STAGES-1:0][15:0] grn_sync_r;
    logic [SYNC_STAGES-1:0]       latch_sync_r;
    // Tracks how far the chain has refilled since reset release.
    logic [SYNC_STAGES-1:0]       fill_sync_r;
    logic                         latch_prev_r;
    // Set once a real 0 has been seen on the latch after reset.
    logic                         armed_r;

    logic [3:0]  row_s;
    logic [15:0] red_s;
    logic [15:0] grn_s;
    logic        latch_s;
    logic        event_s;

    state_t            state_r;
    logic [3:0]        expected_r;
    logic [15:0][15:0] red_shadow_r;
    logic [15:0][15:0] grn_shadow_r;
    logic [TW-1:0]     timeout_r;
    logic              publish_pend_r;

    assign row_s   = row_sync_r[LAST];
    assign red_s   = red_sync_r[LAST];
    assign grn_s   = grn_sync_r[LAST];
    assign latch_s = latch_sync_r[LAST];

    // Latch rising edge, qualified so a level held high across reset is not an edge.
    always_comb begin
        event_s = 1'b0;
        if (armed_r && latch_s && !latch_prev_r) begin
            event_s = 1'b1;
        end else begin
            event_s = 1'b0;
        end
    end

    // Input synchronizers, edge-detect history and post-reset arming.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            row_sync_r   <= '0;
            red_sync_r   <= '0;
            grn_sync_r   <= '0;
            latch_sync_r <= '0;
            fill_sync_r  <= '0;
            latch_prev_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            row_sync_r   <= {row_sync_r[SYNC_STAGES-2:0], scan_row};
            red_sync_r   <= {red_sync_r[SYNC_STAGES-2:0], scan_red};
            grn_sync_r   <= {grn_sync_r[SYNC_STAGES-2:0], scan_grn};
            latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], scan_latch};
            fill_sync_r  <= {fill_sync_r[SYNC_STAGES-2:0], 1'b1};
            latch_prev_r <= latch_s;
            if (fill_sync_r[LAST] && !latch_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Frame tracking FSM: shadow capture, publish, error and timeout handling.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r        <= HUNT;
            expected_r     <= 4'd0;
            red_shadow_r   <= '0;
            grn_shadow_r   <= '0;
            timeout_r      <= '0;
            publish_pend_r <= 1'b0;
            RedPixels      <= '0;
            GrnPixels      <= '0;
            frame_valid    <= 1'b0;
            frame_count    <= 8'd0;
            sync_err       <= 1'b0;
            scan_lost      <= 1'b1;
        end else begin
            frame_valid    <= 1'b0;
            sync_err       <= 1'b0;
            publish_pend_r <= 1'b0;

            if (event_s) begin
                timeout_r <= '0;
            end else if (timeout_r != TO_MAX) begin
                timeout_r <= timeout_r + 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end

            // Publish one cycle after the row-15 write; no event can land in this cycle.
            if (publish_pend_r) begin
                RedPixels   <= red_shadow_r;
                GrnPixels   <= grn_shadow_r;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 8'd1;
                scan_lost   <= 1'b0;
            end else begin
                frame_valid <= 1'b0;
            end

            case (state_r)
                HUNT: begin
                    if (event_s && row_s == 4'd0) begin
                        red_shadow_r[0] <= red_s;
                        grn_shadow_r[0] <= grn_s;
                        expected_r      <= 4'd1;
                        state_r         <= CAPTURE;
                    end else begin
                        state_r <= HUNT;
                    end
                end
                CAPTURE: begin
                    if (event_s) begin
                        if (row_s == expected_r) begin
                            red_shadow_r[row_s] <= red_s;
                            grn_shadow_r[row_s] <= grn_s;
                            expected_r          <= expected_r + 4'd1;
                            publish_pend_r      <= (row_s == 4'd15);
                        end else if (row_s == 4'd0) begin
                            sync_err        <= 1'b1;
                            red_shadow_r[0] <= red_s;
                            grn_shadow_r[0] <= grn_s;
                            expected_r      <= 4'd1;
                        end else begin
                            sync_err   <= 1'b1;
                            scan_lost  <= 1'b1;
                            expected_r <= 4'd0;
                            state_r    <= HUNT;
                        end
                    end else if (timeout_r == TO_MAX) begin
                        scan_lost  <= 1'b1;
                        expected_r <= 4'd0;
                        state_r    <= HUNT;
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                default: begin
                    state_r    <= HUNT;
                    expected_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Testbench for led_scan_decoder: directed scan sequences with a scoreboard
// of expected published frames, checked by a monitor on frame_valid.
module tb_led_scan_decoder;

    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic [15:0][15:0] red;
        logic [15:0][15:0] grn;
        logic [7:0]        fc;
    } frame_t;

    logic              CLK;
    logic              RST;
    logic [3:0]        scan_row;
    logic [15:0]       scan_red;
    logic [15:0]       scan_grn;
    logic              scan_latch;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;
    logic              frame_valid;
    logic [7:0]        frame_count;
    logic              sync_err;
    logic              scan_lost;

    frame_t     exp_q[$];
    int         errors;
    int         checks;
    int         fv_cnt;
    int         se_cnt;
    logic [7:0] exp_fc;

    led_scan_decoder #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .RST(RST),
        .scan_row(scan_row), .scan_red(scan_red), .scan_grn(scan_grn),
        .scan_latch(scan_latch),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels),
        .frame_valid(frame_valid), .frame_count(frame_count),
        .sync_err(sync_err), .scan_lost(scan_lost)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input int kind, input int seed);
        frame_t f;
        f = '0;
        for (int r = 0; r < 16; r++) begin
            case (kind)
                0: begin
                    f.red[r] = 16'h0001 << r;
                    f.grn[r] = ~(16'h0001 << r);
                end
                1: begin
                    f.red[r] = 16'hFFFF;
                    f.grn[r] = 16'hFFFF;
                end
                default: begin
                    f.red[r] = 16'(seed * 37 + r * 4099);
                    f.grn[r] = 16'(seed * 37 + r * 4099) ^ 16'hA5A5;
                end
            endcase
        end
        return f;
    endfunction

    task automatic send_row(input logic [3:0] r, input logic [15:0] rd, input logic [15:0] gn);
        @(posedge CLK); #1;
        scan_latch = 1'b0;
        scan_row   = r;
        scan_red   = rd;
        scan_grn   = gn;
        repeat (4) @(posedge CLK);
        #1 scan_latch = 1'b1;
        repeat (3) @(posedge CLK);
    endtask

    task automatic send_rows(input int lo, input int hi, input int kind, input int seed);
        frame_t f;
        f = make_frame(kind, seed);
        for (int r = lo; r <= hi; r++) begin
            send_row(4'(r), f.red[r], f.grn[r]);
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send_frame(input int kind, input int seed, input bit push);
        frame_t f;
        f = make_frame(kind, seed);
        if (push) begin
            exp_fc = exp_fc + 8'd1;
            f.fc   = exp_fc;
            exp_q.push_back(f);
        end
        send_rows(0, 15, kind, seed);
        settle();
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        frame_t     ref_f;
        int         se_base;
        int         fv_base;
        errors     = 0;
        checks     = 0;
        fv_cnt     = 0;
        se_cnt     = 0;
        exp_fc     = 8'd0;
        RST        = 1'b0;
        scan_row   = 4'd0;
        scan_red   = 16'h0000;
        scan_grn   = 16'h0000;
        scan_latch = 1'b1;

        // Monitor: pops the scoreboard on each publish and counts pulses.
        fork
            begin
                logic fv_prev;
                frame_t e;
                fv_prev = 1'b0;
                forever begin
                    @(negedge CLK);
                    if (RST) begin
                        if (frame_valid) begin
                            fv_cnt++;
                            chk("fv_width", 256'(fv_prev), 256'd0);
                            chk("fv_se_excl", 256'(sync_err), 256'd0);
                            if (exp_q.size() == 0) begin
                                errors++;
                                checks++;
                                $display("FAIL unexpected_publish: got frame_count %0d expected no publish", frame_count);
                            end else begin
                                e = exp_q.pop_front();
                                chk("red_frame", RedPixels, e.red);
                                chk("grn_frame", GrnPixels, e.grn);
                                chk("frame_count", 256'(frame_count), 256'(e.fc));
                            end
                        end
                        if (sync_err) begin
                            se_cnt++;
                        end
                        fv_prev = frame_valid;
                    end else begin
                        fv_prev = 1'b0;
                    end
                end
            end
        join_none

        // Reset state, with scan_latch held high across release and row 0 on the bus.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_red", RedPixels, 256'd0);
        chk("rst_grn", GrnPixels, 256'd0);
        chk("rst_fc", 256'(frame_count), 256'd0);
        chk("rst_lost", 256'(scan_lost), 256'd1);
        chk("rst_fv", 256'(frame_valid), 256'd0);
        chk("rst_se", 256'(sync_err), 256'd0);
        @(posedge CLK); #1 RST = 1'b1;
        repeat (10) @(posedge CLK);
        // A false event at release would make rows 1..15 complete a frame.
        send_rows(1, 15, 0, 0);
        settle();
        chk("held_latch_fc", 256'(frame_count), 256'd0);
        chk("held_latch_lost", 256'(scan_lost), 256'd1);
        chk("held_latch_se", 256'(se_cnt), 256'd0);

        // Clean diagonal frame.
        send_frame(0, 0, 1'b1);
        chk("diag_lost", 256'(scan_lost), 256'd0);
        chk("diag_fc", 256'(frame_count), 256'd1);
        chk("diag_se", 256'(se_cnt), 256'd0);

        // Row 0 arriving mid-frame restarts capture.
        send_rows(0, 7, 0, 0);
        send_frame(1, 0, 1'b1);
        chk("restart_se", 256'(se_cnt), 256'd1);
        chk("restart_fc", 256'(frame_count), 256'd2);
        chk("restart_lost", 256'(scan_lost), 256'd0);

        // Out-of-order row drops to hunting; trailing rows are ignored.
        send_rows(0, 4, 2, 5);
        send_rows(9, 9, 2, 5);
        settle();
        chk("ooo_se", 256'(se_cnt), 256'd2);
        chk("ooo_lost", 256'(scan_lost), 256'd1);
        send_rows(10, 15, 2, 5);
        settle();
        chk("ooo_tail_se", 256'(se_cnt), 256'd2);
        chk("ooo_tail_fc", 256'(frame_count), 256'd2);
        send_frame(2, 7, 1'b1);
        chk("ooo_recover_fc", 256'(frame_count), 256'd3);
        chk("ooo_recover_lost", 256'(scan_lost), 256'd0);

        // Latch gap longer than the timeout.
        ref_f = make_frame(2, 7);
        se_base = se_cnt;
        send_rows(0, 3, 2, 9);
        repeat (TIMEOUT + 5) @(posedge CLK);
        @(negedge CLK);
        chk("to_lost", 256'(scan_lost), 256'd1);
        chk("to_se", 256'(se_cnt - se_base), 256'd0);
        chk("to_fc", 256'(frame_count), 256'd3);
        chk("to_red_kept", RedPixels, ref_f.red);
        chk("to_grn_kept", GrnPixels, ref_f.grn);
        send_frame(0, 0, 1'b1);
        chk("to_recover_lost", 256'(scan_lost), 256'd0);
        chk("to_recover_fc", 256'(frame_count), 256'd4);

        // Reset in the middle of a frame.
        send_rows(0, 10, 2, 11);
        @(posedge CLK); #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("mid_rst_red", RedPixels, 256'd0);
        chk("mid_rst_grn", GrnPixels, 256'd0);
        chk("mid_rst_fc", 256'(frame_count), 256'd0);
        chk("mid_rst_lost", 256'(scan_lost), 256'd1);
        exp_fc = 8'd0;
        @(posedge CLK); #1 RST = 1'b1;
        send_rows(11, 15, 2, 11);
        settle();
        chk("mid_rst_tail_fc", 256'(frame_count), 256'd0);
        chk("mid_rst_tail_lost", 256'(scan_lost), 256'd1);
        chk("mid_rst_tail_q", 256'(exp_q.size()), 256'd0);

        // Frame counter wrap over 257 frames.
        fv_base = fv_cnt;
        se_base = se_cnt;
        for (int f = 0; f < 257; f++) begin
            send_frame(2, f, 1'b1);
        end
        chk("wrap_pulses", 256'(fv_cnt - fv_base), 256'd257);
        chk("wrap_fc", 256'(frame_count), 256'd1);
        chk("wrap_lost", 256'(scan_lost), 256'd0);
        chk("wrap_se", 256'(se_cnt - se_base), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
